// File: rtl/fir_out_pkg.sv
// Shared constants and the scaling helper for the FIR output decimator.
package fir_out_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 8;
    localparam int SHIFT_DEF = 4;
    localparam int DECIM_DEF = 2;
    localparam int DEPTH_DEF = 4;

    // Working width for the helper; one spare bit keeps the rounding add from wrapping.
    localparam int RS_W = 32;

    // Returns {sat, value}: round-half-up shift, then clamp to out_w bits.
    function automatic logic [RS_W:0] round_sat(input logic [RS_W-1:0] din,
                                                input int shift,
                                                input int out_w);
        logic [RS_W:0] r;
        logic [RS_W:0] max_v;
        r = {1'b0, din};
        if (shift > 0) begin
            r = (r + ((RS_W+1)'(1) << (shift - 1))) >> shift;
        end
        max_v = ((RS_W+1)'(1) << out_w) - (RS_W+1)'(1);
        if (r > max_v) begin
            return {1'b1, max_v[RS_W-1:0]};
        end
        return {1'b0, r[RS_W-1:0]};
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Show-ahead sample FIFO with extra-bit pointers; a pop frees a slot for a same-cycle push.
module fir_sample_fifo
    import fir_out_pkg::*;
#(
    parameter int W     = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fir_out_decimator.sv
// Keeps every DECIM-th filter sample, rounds/shifts/saturates it, and buffers it for a stalling consumer.
module fir_out_decimator
    import fir_out_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          din,
    input  logic                     din_valid,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     sat_seen
);

    localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECIM - 1);

    logic [DC_W-1:0]  dcnt;
    logic             keep;
    logic [RS_W:0]    scaled;
    logic             unused_scaled_hi;
    logic [OUT_W-1:0] s1_data;
    logic             s1_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign keep             = din_valid && (dcnt == '0);
    assign scaled           = round_sat(RS_W'(din), SHIFT, OUT_W);
    assign unused_scaled_hi = ^scaled[RS_W-1:OUT_W];
    assign dout_valid       = ~fifo_empty;
    assign pop              = dout_valid & dout_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dcnt     <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            sat_seen <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (din_valid) dcnt <= (dcnt == DC_LAST) ? '0 : dcnt + DC_W'(1);
            s1_valid <= keep;
            if (keep) begin
                s1_data <= scaled[OUT_W-1:0];
                if (scaled[RS_W]) sat_seen <= 1'b1;
            end
            // A full FIFO only rejects the write when nothing leaves in the same cycle.
            if (s1_valid && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    fir_sample_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s1_valid),
        .wdata (s1_data),
        .pop   (pop),
        .rdata (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule
